bin_avg_readout: RTL

BIN_AVG_READOUT -- requirements
Module: bin_avg_readout

---
 rtl/bin_avg_pkg.sv | 14 +
 rtl/bin_avg_readout.sv | 111 +++++++++++
 2 files changed

// File: rtl/bin_avg_pkg.sv
// Shared definitions for the N-bin averager and its frame readout serializer.
package bin_avg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    localparam logic [7:0] HDR_MAGIC     = 8'hB1;
    localparam int         DEF_N_LANES   = 4;
    localparam int         DEF_SUM_WIDTH = 128;

endpackage

// File: rtl/bin_avg_readout.sv
// Captures one frame of lane sums and streams it out as a header word followed
// by every lane, least-significant slice first, under valid/ready flow control.
module bin_avg_readout
    import bin_avg_pkg::*;
#(
    parameter int N_LANES   = DEF_N_LANES,
    parameter int SUM_WIDTH = DEF_SUM_WIDTH,
    parameter int OUT_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_LANES-1:0][SUM_WIDTH-1:0] in_sum,
    input  logic                              in_valid,
    output logic                              busy,
    output logic [OUT_WIDTH-1:0]              out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic [15:0]                       drop_cnt
);

    localparam int WPL    = SUM_WIDTH / OUT_WIDTH;
    localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int WORD_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WPL - 1);

    state_t                             state;
    state_t                             state_nxt;
    logic [N_LANES-1:0][SUM_WIDTH-1:0]  cap;
    logic [LANE_W-1:0]                  lane_idx;
    logic [WORD_W-1:0]                  word_idx;
    logic [15:0]                        seq;
    logic [15:0]                        hdr_seq;
    logic [31:0]                        hdr_word;
    logic                               accept;
    logic                               last_word;
    logic                               drop;

    always_comb begin
        accept    = (state == IDLE) && in_valid;
        drop      = (state != IDLE) && in_valid;
        last_word = (state == DATA) && (lane_idx == LAST_LANE) && (word_idx == LAST_WORD);
        hdr_word  = {HDR_MAGIC, 8'(N_LANES), hdr_seq};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)               state_nxt = HEADER;
            HEADER:  if (out_ready)              state_nxt = DATA;
            DATA:    if (out_ready && last_word) state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Frame payload and its sequence tag are pure data; only accept gates them.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap     <= in_sum;
            hdr_seq <= seq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_idx <= '0;
            word_idx <= '0;
            seq      <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                lane_idx <= '0;
                word_idx <= '0;
                seq      <= seq + 16'd1;
            end else if ((state == DATA) && out_ready) begin
                if (word_idx == LAST_WORD) begin
                    word_idx <= '0;
                    lane_idx <= lane_idx + LANE_W'(1);
                end else begin
                    word_idx <= word_idx + WORD_W'(1);
                end
            end
            // A strobe landing on the final handshake still counts as lost.
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        out_valid = (state != IDLE);
        busy      = (state != IDLE);
        out_last  = last_word;
        out_data  = '0;
        case (state)
            HEADER:  out_data = OUT_WIDTH'(hdr_word);
            DATA:    out_data = cap[lane_idx][word_idx*OUT_WIDTH +: OUT_WIDTH];
            default: out_data = '0;
        endcase
    end

endmodule
